// File: rtl/nios2_mul_result_assembler.sv
// rtl/nios2_mul_result_assembler.sv - assembles MUL/MULX results from 16x16 partial products
module nios2_mul_result_assembler #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        mul_en,
  input  logic [31:0] p1,
  input  logic [31:0] p2,
  input  logic [31:0] p3,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int ITERS = 16 / BITS_PER_CYCLE;
  localparam logic [4:0] ITERS_W = 5'(ITERS);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  typedef enum logic [2:0] {IDLE, CAPT, ITER, FIX, DONE} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [32:0] mid_q;
  logic        c_q;
  logic [31:0] hh;
  logic [31:0] ash;
  logic [15:0] bsh;
  logic [4:0]  cnt;

  logic [32:0] mid_now;
  logic [32:0] lo_sum;
  logic [31:0] hu;
  logic [31:0] fixed;
  logic [31:0] term;

  // Cell enable is a pure function of the request and our busy flag.
  assign mul_en = start & ~busy;

  // Datapath: middle-term sum, low-word sum with carry-out, and one shift-add term.
  always_comb begin
    mid_now = {1'b0, p2} + {1'b0, p3};
    lo_sum  = {1'b0, p1} + {1'b0, mid_now[15:0], 16'h0000};
    hu      = hh + {15'b0, mid_q[32:16]} + {31'b0, c_q};
    term    = ash * {{(32-BITS_PER_CYCLE){1'b0}}, bsh[BITS_PER_CYCLE-1:0]};
  end

  // Signed corrections turn the unsigned high word into the signed variants.
  always_comb begin
    fixed = hu;
    if (op_q[1] && a_q[31])
      fixed = fixed - b_q;
    if ((op_q == OP_MULXSS) && b_q[31])
      fixed = fixed - a_q;
  end

  // Sequencer: accept, capture partials, iterate aH*bH, correct, pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      a_q    <= 32'h0;
      b_q    <= 32'h0;
      mid_q  <= 33'h0;
      c_q    <= 1'b0;
      hh     <= 32'h0;
      ash    <= 32'h0;
      bsh    <= 16'h0;
      cnt    <= 5'h0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= src1;
            b_q   <= src2;
            busy  <= 1'b1;
            state <= CAPT;
          end
        end
        CAPT: begin
          mid_q <= mid_now;
          c_q   <= lo_sum[32];
          if (op_q == OP_MUL) begin
            result <= lo_sum[31:0];
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            hh    <= 32'h0;
            ash   <= {16'h0000, a_q[31:16]};
            bsh   <= b_q[31:16];
            cnt   <= ITERS_W;
            state <= ITER;
          end
        end
        ITER: begin
          // Fixed iteration count: no early exit even when bsh runs out of ones.
          hh  <= hh + term;
          ash <= ash << BITS_PER_CYCLE;
          bsh <= bsh >> BITS_PER_CYCLE;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1)
            state <= FIX;
        end
        FIX: begin
          result <= fixed;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_mul_result_assembler.sv
// tb/tb_nios2_mul_result_assembler.sv - randomized self-checking bench for the MUL result assembler
module tb_nios2_mul_result_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic [31:0] p1, p2, p3;
  logic        mul_en1, busy1, done1;
  logic [31:0] result1;
  logic        mul_en4, busy4, done4;
  logic [31:0] result4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  nios2_mul_result_assembler #(.BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .mul_en(mul_en1), .p1(p1), .p2(p2), .p3(p3),
    .busy(busy1), .done(done1), .result(result1)
  );

  nios2_mul_result_assembler #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .mul_en(mul_en4), .p1(p1), .p2(p2), .p3(p3),
    .busy(busy4), .done(done4), .result(result4)
  );

  // Multiplier cell model: partial products registered one cycle after enable.
  always @(posedge clk) begin
    if (mul_en1 | mul_en4) begin
      p1 <= {16'h0, src1[15:0]}  * {16'h0, src2[15:0]};
      p2 <= {16'h0, src1[15:0]}  * {16'h0, src2[31:16]};
      p3 <= {16'h0, src1[31:16]} * {16'h0, src2[15:0]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Full 64-bit product with the operand signedness each opcode implies.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] prod;
    sa = o[1]        ? longint'($signed(a)) : longint'({32'h0, a});
    sb = (o == 2'b11) ? longint'($signed(b)) : longint'({32'h0, b});
    prod = 64'(sa * sb);
    return (o == 2'b00) ? prod[31:0] : prod[63:32];
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int cyc, lat1, lat4;
    bit seen1, seen4;
    logic [31:0] r1, r4;
    seen1 = 0; seen4 = 0; lat1 = 0; lat4 = 0; r1 = 0; r4 = 0; cyc = 0;
    @(negedge clk);
    op = o; src1 = a; src2 = b; start = 1'b1;
    #1;
    check({tag, " mul_en"}, {31'b0, mul_en1}, 32'd1);
    check({tag, " idle_done"}, {31'b0, done1}, 32'd0);
    while (!(seen1 && seen4) && cyc < 40) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      #1;
      if (cyc == 1) check({tag, " busy"}, {31'b0, busy1}, 32'd1);
      if (done1 && !seen1) begin seen1 = 1; lat1 = cyc; r1 = result1; end
      if (done4 && !seen4) begin seen4 = 1; lat4 = cyc; r4 = result4; end
    end
    check({tag, " done_seen"}, {30'b0, seen1, seen4}, 32'd3);
    check({tag, " result_b1"}, r1, exp);
    check({tag, " result_b4"}, r4, exp);
    check({tag, " lat_b1"}, 32'(lat1), (o == 2'b00) ? 32'd2 : 32'd19);
    check({tag, " lat_b4"}, 32'(lat4), (o == 2'b00) ? 32'd2 : 32'd7);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy1 || busy4) && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_idle", {30'b0, busy1, busy4}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc, en_cnt;
    bit seen;
    logic [31:0] r, a, b;
    logic [1:0] o;

    reset = 1'b1; start = 1'b0; op = 2'b00; src1 = 32'h0; src2 = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst busy", {30'b0, busy1, busy4}, 32'd0);
    check("rst done", {30'b0, done1, done4}, 32'd0);
    check("rst result_b1", result1, 32'h0);
    check("rst result_b4", result4, 32'h0);
    check("rst mul_en", {30'b0, mul_en1, mul_en4}, 32'd0);
    reset = 1'b0;

    // Directed results with known answers.
    run_op("T1 mul",    2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    run_op("T1 mulxuu", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
    run_op("T2 mul",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("T2 mulxuu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("T2 mulxss", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("T3 mulxsu", 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    run_op("T3 mulxss", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

    // Start held every cycle: only one accept, operands stay latched.
    a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(negedge clk);
    op = 2'b01; src1 = a; src2 = b; start = 1'b1;
    #1;
    en_cnt = mul_en1 ? 1 : 0;
    cyc = 0; seen = 0; r = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      src1 = $urandom; src2 = $urandom;
      cyc++;
      #1;
      if (mul_en1) en_cnt++;
      if (done1) begin seen = 1; r = result1; end
    end
    check("T4 en_pulses", 32'(en_cnt), 32'd1);
    check("T4 latency", 32'(cyc), 32'd19);
    check("T4 result", r, ref_mul(2'b01, a, b));
    @(negedge clk);
    #1;
    check("T4 reaccept", {31'b0, mul_en1}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of iteration aborts without a done pulse.
    run_op("T5 pre", 2'b00, 32'd7, 32'd9, 32'd63);
    @(negedge clk);
    op = 2'b01; src1 = $urandom; src2 = $urandom; start = 1'b1;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("T5 busy", {30'b0, busy1, busy4}, 32'd0);
    check("T5 result_b1", result1, 32'h0);
    check("T5 result_b4", result4, 32'h0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (done1 || done4) seen = 1;
    end
    reset = 1'b0;
    repeat (25) begin
      @(negedge clk);
      #1;
      if (done1 || done4) seen = 1;
    end
    check("T5 no_done", {31'b0, seen}, 32'd0);
    run_op("T5 mul", 2'b00, 32'd3, 32'd5, 32'd15);

    // Random ops against the 64-bit reference, with corner operands mixed in.
    for (int i = 0; i < 1200; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h0000_FFFF;
        3: b = 32'h7FFF_FFFF;
        default: ;
      endcase
      run_op("T6 rand", o, a, b, ref_mul(o, a, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
